// File: rtl/genaxis_descriptor_gen.sv
// Packet-descriptor source for the AXI-Stream traffic generator: emits {channel, pause, length}
// on valid/ready. Define GENAXIS_DESC_GEN_PAUSE_JITTER_EN to add PRNG-driven pause jitter.

module genaxis_descriptor_gen #(
  parameter int ID_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start_i,
  input  logic                   cfg_stop_i,
  input  logic [31:0]            cfg_pkt_count_i,
  input  logic [1:0]             cfg_len_mode_i,
  input  logic [15:0]            cfg_len_min_i,
  input  logic [15:0]            cfg_len_max_i,
  input  logic [31:0]            cfg_pause_i,
`ifdef GENAXIS_DESC_GEN_PAUSE_JITTER_EN
  input  logic [15:0]            cfg_pause_jitter_i,
`endif
  input  logic                   cfg_chan_mode_i,
  input  logic [ID_WIDTH-1:0]    cfg_chan_base_i,
  input  logic [ID_WIDTH-1:0]    cfg_chan_num_i,
  input  logic [31:0]            psrand_data_i,
  output logic [47+ID_WIDTH:0]   out_descriptor_data_o,
  output logic                   out_descriptor_valid_o,
  input  logic                   out_descriptor_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            sent_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_STOP} state_t;

  state_t                 r_state;
  logic [47+ID_WIDTH:0]   r_data;
  logic                   r_valid;
  logic                   r_done;
  logic [31:0]            r_sent_count;

  logic [31:0]            r_pkt_count;
  logic [1:0]             r_len_mode;
  logic [15:0]            r_len_min;
  logic [15:0]            r_len_max;
  logic [15:0]            r_span;
  logic [15:0]            r_span_mask;
  logic [31:0]            r_pause;
  logic                   r_chan_mode;
  logic [ID_WIDTH-1:0]    r_chan_base;
  logic [ID_WIDTH-1:0]    r_chan_num;
  logic [15:0]            r_len_inc;
  logic [ID_WIDTH-1:0]    r_chan_off;

  logic [15:0]            w_min_clamp;
  logic [15:0]            w_max_clamp;
  logic [15:0]            w_span_new;
  logic [15:0]            w_mask_new;
  logic [15:0]            w_rand_c;
  logic [15:0]            w_rand_off;
  logic [15:0]            w_len;
  logic [15:0]            w_len_inc_next;
  logic [ID_WIDTH-1:0]    w_chan;
  logic [ID_WIDTH-1:0]    w_chan_off_next;
  logic [31:0]            w_pause;
  logic [47+ID_WIDTH:0]   w_desc;
  logic                   w_start;
  logic                   w_hs;
  logic                   w_last;
  logic                   w_advance;
  logic [31:0]            w_sent_inc;

  // Clamp the incoming range and smear the span down to an all-ones mask.
  always_comb begin
    w_min_clamp = (cfg_len_min_i == 16'd0) ? 16'd1 : cfg_len_min_i;
    w_max_clamp = (cfg_len_max_i < w_min_clamp) ? w_min_clamp : cfg_len_max_i;
    w_span_new  = w_max_clamp - w_min_clamp;
    w_mask_new  = w_span_new | (w_span_new >> 1);
    w_mask_new  = w_mask_new | (w_mask_new >> 2);
    w_mask_new  = w_mask_new | (w_mask_new >> 4);
    w_mask_new  = w_mask_new | (w_mask_new >> 8);
  end

  // NOTE: every variable driven here has a value on every path (case default), so no latch is inferred.
  always_comb begin
    w_rand_c   = psrand_data_i[15:0] & r_span_mask;
    w_rand_off = (w_rand_c > r_span) ? (w_rand_c - r_span - 16'd1) : w_rand_c;
    case (r_len_mode)
      2'd1:    w_len = r_len_inc;
      2'd2:    w_len = r_len_min + w_rand_off;
      default: w_len = r_len_min;
    endcase
    w_len_inc_next  = (r_len_inc >= r_len_max) ? r_len_min : (r_len_inc + 16'd1);
    w_chan          = r_chan_mode ? (r_chan_base + r_chan_off) : r_chan_base;
    w_chan_off_next = (r_chan_off == (r_chan_num - ID_WIDTH'(1))) ? '0
                                                                  : (r_chan_off + ID_WIDTH'(1));
  end

`ifdef GENAXIS_DESC_GEN_PAUSE_JITTER_EN
  logic [15:0] r_jitter;
  logic [32:0] w_pause_sum;

  always_ff @(posedge clk) begin
    if (w_start) r_jitter <= cfg_pause_jitter_i;
  end

  assign w_pause_sum = {1'b0, r_pause} + {17'd0, psrand_data_i[31:16] & r_jitter};
  assign w_pause     = w_pause_sum[32] ? 32'hFFFF_FFFF : w_pause_sum[31:0];
`else
  logic w_unused_psrand_hi;
  assign w_unused_psrand_hi = ^psrand_data_i[31:16];
  assign w_pause            = r_pause;
`endif

  assign w_desc     = {w_chan, w_pause, w_len};
  assign w_start    = (r_state == ST_IDLE) && cfg_start_i;
  assign w_hs       = r_valid && out_descriptor_ready_i;
  assign w_sent_inc = r_sent_count + 32'd1;
  assign w_last     = (r_pkt_count != 32'd0) && (w_sent_inc == r_pkt_count);
  assign w_advance  = (r_state == ST_LOAD) ||
                      ((r_state == ST_RUN) && w_hs && !w_last && !cfg_stop_i);

  // NOTE: shadows and generator counters have no reset; each start reloads them before first use.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_pkt_count <= cfg_pkt_count_i;
      r_len_mode  <= cfg_len_mode_i;
      r_len_min   <= w_min_clamp;
      r_len_max   <= w_max_clamp;
      r_span      <= w_span_new;
      r_span_mask <= w_mask_new;
      r_pause     <= cfg_pause_i;
      r_chan_mode <= cfg_chan_mode_i;
      r_chan_base <= cfg_chan_base_i;
      r_chan_num  <= (cfg_chan_num_i == '0) ? ID_WIDTH'(1) : cfg_chan_num_i;
      r_len_inc   <= w_min_clamp;
      r_chan_off  <= '0;
    end else if (w_advance) begin
      r_len_inc   <= w_len_inc_next;
      r_chan_off  <= w_chan_off_next;
    end
  end

  // NOTE: state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_sent_count <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start_i) begin
            r_sent_count <= 32'd0;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_data  <= w_desc;
          r_valid <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_hs) begin
            r_sent_count <= w_sent_inc;
            if (w_last || cfg_stop_i) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_data <= w_desc;
            end
          end else if (cfg_stop_i) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_hs) begin
            r_sent_count <= w_sent_inc;
            r_valid      <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_descriptor_data_o  = r_data;
  assign out_descriptor_valid_o = r_valid;
  assign busy_o                 = (r_state != ST_IDLE);
  assign done_o                 = r_done;
  assign sent_count_o           = r_sent_count;

endmodule

// File: tb/tb_genaxis_descriptor_gen.sv
// Scoreboard bench for genaxis_descriptor_gen: expected descriptors are queued at configuration
// time and popped on every observed handshake; scenario tasks check control behaviour inline.

module tb_genaxis_descriptor_gen;

  localparam int ID_WIDTH = 10;
  localparam int DW       = 48 + ID_WIDTH;
  typedef logic [DW-1:0] desc_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_start_i;
  logic                cfg_stop_i;
  logic [31:0]         cfg_pkt_count_i;
  logic [1:0]          cfg_len_mode_i;
  logic [15:0]         cfg_len_min_i;
  logic [15:0]         cfg_len_max_i;
  logic [31:0]         cfg_pause_i;
`ifdef GENAXIS_DESC_GEN_PAUSE_JITTER_EN
  logic [15:0]         cfg_pause_jitter_i;
`endif
  logic                cfg_chan_mode_i;
  logic [ID_WIDTH-1:0] cfg_chan_base_i;
  logic [ID_WIDTH-1:0] cfg_chan_num_i;
  logic [31:0]         psrand_data_i;
  desc_t               out_descriptor_data_o;
  logic                out_descriptor_valid_o;
  logic                out_descriptor_ready_i;
  logic                busy_o;
  logic                done_o;
  logic [31:0]         sent_count_o;

  always #5 clk = ~clk;

  genaxis_descriptor_gen #(.ID_WIDTH(ID_WIDTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cfg_start_i            (cfg_start_i),
    .cfg_stop_i             (cfg_stop_i),
    .cfg_pkt_count_i        (cfg_pkt_count_i),
    .cfg_len_mode_i         (cfg_len_mode_i),
    .cfg_len_min_i          (cfg_len_min_i),
    .cfg_len_max_i          (cfg_len_max_i),
    .cfg_pause_i            (cfg_pause_i),
`ifdef GENAXIS_DESC_GEN_PAUSE_JITTER_EN
    .cfg_pause_jitter_i     (cfg_pause_jitter_i),
`endif
    .cfg_chan_mode_i        (cfg_chan_mode_i),
    .cfg_chan_base_i        (cfg_chan_base_i),
    .cfg_chan_num_i         (cfg_chan_num_i),
    .psrand_data_i          (psrand_data_i),
    .out_descriptor_data_o  (out_descriptor_data_o),
    .out_descriptor_valid_o (out_descriptor_valid_o),
    .out_descriptor_ready_i (out_descriptor_ready_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .sent_count_o           (sent_count_o)
  );

  desc_t sb_q[$];
  desc_t sb_exp;
  int    n_pass   = 0;
  int    n_total  = 0;
  int    hs_count = 0;
  bit    sb_en    = 1'b0;

  function automatic desc_t mk_desc(input int unsigned ch, input logic [31:0] pause,
                                    input int unsigned len);
    logic [ID_WIDTH-1:0] c;
    logic [15:0]         l;
    c = ch[ID_WIDTH-1:0];
    l = len[15:0];
    return {c, pause, l};
  endfunction

  // Scoreboard: every handshake pops one expected descriptor.
  always @(negedge clk) begin
    if (sb_en && out_descriptor_valid_o && out_descriptor_ready_i) begin
      hs_count++;
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_extra: got descriptor %h, required no handshake", out_descriptor_data_o);
      end else begin
        sb_exp = sb_q.pop_front();
        if (out_descriptor_data_o !== sb_exp)
          $display("FAIL sb_desc: got %h, required %h", out_descriptor_data_o, sb_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int unsigned count, input logic [1:0] lmode,
                           input int unsigned lmin, input int unsigned lmax,
                           input logic [31:0] pause, input logic cmode,
                           input int unsigned cbase, input int unsigned cnum);
    cfg_pkt_count_i = count;
    cfg_len_mode_i  = lmode;
    cfg_len_min_i   = 16'(lmin);
    cfg_len_max_i   = 16'(lmax);
    cfg_pause_i     = pause;
    cfg_chan_mode_i = cmode;
    cfg_chan_base_i = ID_WIDTH'(cbase);
    cfg_chan_num_i  = ID_WIDTH'(cnum);
  endtask

  task automatic pulse_start();
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_total++; if (out_descriptor_valid_o !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_descriptor_valid_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b, required 0", done_o); else n_pass++;
    n_total++; if (sent_count_o !== 32'd0) $display("FAIL rst_sent: got %0d, required 0", sent_count_o); else n_pass++;
    n_total++; if (out_descriptor_data_o !== '0) $display("FAIL rst_data: got %h, required 0", out_descriptor_data_o); else n_pass++;
    reset = 1'b0;
    step();
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_idle_busy: got %b, required 0", busy_o); else n_pass++;
  endtask

  task automatic test_fixed();
    bit seen; int lat;
    configure(4, 2'd0, 64, 0, 32'd10, 1'b0, 3, 0);
    out_descriptor_ready_i = 1'b1;
    psrand_data_i = $urandom;
    hs_count = 0; sb_en = 1'b1;
    repeat (4) sb_q.push_back(mk_desc(3, 32'd10, 64));
    pulse_start();
    n_total++; if (out_descriptor_valid_o !== 1'b0) $display("FAIL fixed_load_valid: got %b, required 0", out_descriptor_valid_o); else n_pass++;
    n_total++; if (busy_o !== 1'b1) $display("FAIL fixed_load_busy: got %b, required 1", busy_o); else n_pass++;
    step();
    n_total++; if (out_descriptor_valid_o !== 1'b1) $display("FAIL fixed_first_valid: got %b, required 1", out_descriptor_valid_o); else n_pass++;
    run_until_done(20, seen, lat);
    n_total++; if (!seen) $display("FAIL fixed_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL fixed_done_latency: got %0d, required 4", lat); else n_pass++;
    n_total++; if (out_descriptor_valid_o !== 1'b0) $display("FAIL fixed_end_valid: got %b, required 0", out_descriptor_valid_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL fixed_end_busy: got %b, required 0", busy_o); else n_pass++;
    n_total++; if (sent_count_o !== 32'd4) $display("FAIL fixed_sent: got %0d, required 4", sent_count_o); else n_pass++;
    n_total++; if (hs_count != 4) $display("FAIL fixed_hs: got %0d, required 4", hs_count); else n_pass++;
    @(negedge clk);
    n_total++; if (done_o !== 1'b0) $display("FAIL fixed_done_width: got %b, required 0", done_o); else n_pass++;
    step();
  endtask

  task automatic test_incr_rr();
    bit seen; int lat;
    int unsigned lens[5]  = '{1, 2, 3, 1, 2};
    int unsigned chans[5] = '{5, 6, 5, 6, 5};
    configure(5, 2'd1, 1, 3, 32'hDEAD_BEEF, 1'b1, 5, 2);
    out_descriptor_ready_i = 1'b1;
    hs_count = 0;
    for (int i = 0; i < 5; i++) sb_q.push_back(mk_desc(chans[i], 32'hDEAD_BEEF, lens[i]));
    pulse_start();
    configure(9, 2'd2, 7, 9, 32'h0000_1234, 1'b0, 100, 7);
    psrand_data_i = $urandom;
    step();
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    run_until_done(20, seen, lat);
    n_total++; if (!seen) $display("FAIL incr_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (sent_count_o !== 32'd5) $display("FAIL incr_sent: got %0d, required 5", sent_count_o); else n_pass++;
    n_total++; if (hs_count != 5) $display("FAIL incr_hs: got %0d, required 5", hs_count); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL incr_leftover: got %0d, required 0", sb_q.size()); else n_pass++;
    step();
  endtask

  task automatic test_boundaries();
    bit seen; int lat;
    int unsigned lens[4]  = '{65534, 65535, 65534, 65535};
    int unsigned chans[4] = '{1022, 1023, 0, 1022};
    configure(4, 2'd1, 65534, 65535, 32'hFFFF_FFFF, 1'b1, 1022, 3);
    out_descriptor_ready_i = 1'b1;
    hs_count = 0;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk_desc(chans[i], 32'hFFFF_FFFF, lens[i]));
    pulse_start();
    run_until_done(20, seen, lat);
    n_total++; if (!seen) $display("FAIL wrap_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (hs_count != 4) $display("FAIL wrap_hs: got %0d, required 4", hs_count); else n_pass++;
    step();
    configure(3, 2'd3, 0, 500, 32'd77, 1'b1, 9, 0);
    hs_count = 0;
    repeat (3) sb_q.push_back(mk_desc(9, 32'd77, 1));
    pulse_start();
    run_until_done(20, seen, lat);
    n_total++; if (!seen) $display("FAIL clamp_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (hs_count != 3) $display("FAIL clamp_hs: got %0d, required 3", hs_count); else n_pass++;
    step();
  endtask

  task automatic test_random();
    bit seen; int lat;
    configure(3, 2'd2, 100, 105, 32'd55, 1'b0, 12, 0);
    out_descriptor_ready_i = 1'b1;
    psrand_data_i = 32'hABCD_000F;
    hs_count = 0;
    repeat (3) sb_q.push_back(mk_desc(12, 32'd55, 101));
    pulse_start();
    run_until_done(20, seen, lat);
    n_total++; if (!seen) $display("FAIL rand_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (hs_count != 3) $display("FAIL rand_hs: got %0d, required 3", hs_count); else n_pass++;
    step();
  endtask

  task automatic test_random_sweep();
    bit seen; int lat;
    int unsigned vals[$];
    int unsigned c, exp_len;
    logic [15:0] got;
    for (int v = 0; v < 256; v++) vals.push_back(v);
    for (int v = 256; v < 65536; v += 251) vals.push_back(v);
    vals.push_back(65535);
    sb_en = 1'b0;
    configure(0, 2'd2, 100, 105, 32'd1, 1'b0, 12, 0);
    out_descriptor_ready_i = 1'b1;
    pulse_start();
    foreach (vals[k]) begin
      psrand_data_i = {16'h5A5A, 16'(vals[k])};
      step();
      got     = out_descriptor_data_o[15:0];
      c       = vals[k] & 7;
      exp_len = 100 + ((c > 5) ? c - 6 : c);
      n_total++; if (got !== 16'(exp_len)) $display("FAIL sweep_len ps=%0d: got %0d, required %0d", vals[k], got, exp_len); else n_pass++;
      n_total++; if (got < 16'd100 || got > 16'd105) $display("FAIL sweep_range ps=%0d: got %0d, required 100..105", vals[k], got); else n_pass++;
    end
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
    run_until_done(10, seen, lat);
    n_total++; if (!seen) $display("FAIL sweep_stop_timeout: got no done, required done"); else n_pass++;
    step();
    sb_en = 1'b1;
  endtask

  task automatic test_backpressure();
    bit seen; int lat; int stalls; bit prev_stall; desc_t prev_data;
    configure(3, 2'd1, 10, 20, 32'd1000, 1'b0, 7, 0);
    out_descriptor_ready_i = 1'b0;
    hs_count = 0; stalls = 0; prev_stall = 1'b0; seen = 1'b0; prev_data = '0;
    for (int i = 10; i < 13; i++) sb_q.push_back(mk_desc(7, 32'd1000, i));
    pulse_start();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (prev_stall) begin
        stalls++;
        n_total++;
        if (out_descriptor_valid_o !== 1'b1 || out_descriptor_data_o !== prev_data)
          $display("FAIL bp_hold: got valid=%b data=%h, required valid=1 data=%h", out_descriptor_valid_o, out_descriptor_data_o, prev_data);
        else n_pass++;
      end
      prev_stall = out_descriptor_valid_o && !out_descriptor_ready_i;
      prev_data  = out_descriptor_data_o;
      if (done_o === 1'b1) seen = 1'b1;
      psrand_data_i = $urandom;
      @(posedge clk);
      #1;
      out_descriptor_ready_i = ~out_descriptor_ready_i;
    end
    n_total++; if (!seen) $display("FAIL bp_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (hs_count != 3) $display("FAIL bp_hs: got %0d, required 3", hs_count); else n_pass++;
    n_total++; if (sent_count_o !== 32'd3) $display("FAIL bp_sent: got %0d, required 3", sent_count_o); else n_pass++;
    n_total++; if (stalls == 0) $display("FAIL bp_stalls: got 0 stall cycles, required >0"); else n_pass++;
  endtask

  task automatic test_stop_stalled();
    bit seen; int lat;
    desc_t exp_d;
    exp_d = mk_desc(2, 32'd3, 50);
    configure(0, 2'd0, 50, 60, 32'd3, 1'b0, 2, 0);
    out_descriptor_ready_i = 1'b0;
    hs_count = 0;
    sb_q.push_back(exp_d);
    pulse_start();
    step();
    step();
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
    n_total++; if (busy_o !== 1'b1) $display("FAIL stop_busy: got %b, required 1", busy_o); else n_pass++;
    n_total++; if (out_descriptor_valid_o !== 1'b1) $display("FAIL stop_valid: got %b, required 1", out_descriptor_valid_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL stop_early_done: got %b, required 0", done_o); else n_pass++;
    psrand_data_i = $urandom;
    step();
    step();
    n_total++; if (out_descriptor_data_o !== exp_d) $display("FAIL stop_hold: got %h, required %h", out_descriptor_data_o, exp_d); else n_pass++;
    n_total++; if (sent_count_o !== 32'd0) $display("FAIL stop_sent0: got %0d, required 0", sent_count_o); else n_pass++;
    out_descriptor_ready_i = 1'b1;
    run_until_done(10, seen, lat);
    n_total++; if (!seen) $display("FAIL stop_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (out_descriptor_valid_o !== 1'b0) $display("FAIL stop_end_valid: got %b, required 0", out_descriptor_valid_o); else n_pass++;
    n_total++; if (sent_count_o !== 32'd1) $display("FAIL stop_sent: got %0d, required 1", sent_count_o); else n_pass++;
    n_total++; if (hs_count != 1) $display("FAIL stop_hs: got %0d, required 1", hs_count); else n_pass++;
    step();
  endtask

  task automatic test_stop_accept();
    bit seen; int lat;
    configure(0, 2'd0, 77, 77, 32'd0, 1'b0, 1, 0);
    out_descriptor_ready_i = 1'b1;
    hs_count = 0;
    repeat (3) sb_q.push_back(mk_desc(1, 32'd0, 77));
    pulse_start();
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
    n_total++; if (out_descriptor_valid_o !== 1'b1) $display("FAIL acc_load_stop: got valid %b, required 1", out_descriptor_valid_o); else n_pass++;
    step();
    step();
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
    run_until_done(10, seen, lat);
    n_total++; if (!seen) $display("FAIL acc_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (lat != 0) $display("FAIL acc_done_latency: got %0d, required 0", lat); else n_pass++;
    n_total++; if (sent_count_o !== 32'd3) $display("FAIL acc_sent: got %0d, required 3", sent_count_o); else n_pass++;
    n_total++; if (hs_count != 3) $display("FAIL acc_hs: got %0d, required 3", hs_count); else n_pass++;
    step();
  endtask

  task automatic test_reset_midrun();
    bit seen; int lat;
    sb_en = 1'b0;
    configure(0, 2'd1, 20, 30, 32'd9, 1'b1, 4, 3);
    out_descriptor_ready_i = 1'b1;
    pulse_start();
    repeat (4) step();
    reset = 1'b1;
    step();
    n_total++; if (out_descriptor_valid_o !== 1'b0) $display("FAIL mrst_valid: got %b, required 0", out_descriptor_valid_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL mrst_busy: got %b, required 0", busy_o); else n_pass++;
    n_total++; if (sent_count_o !== 32'd0) $display("FAIL mrst_sent: got %0d, required 0", sent_count_o); else n_pass++;
    reset = 1'b0;
    step();
    n_total++; if (done_o !== 1'b0) $display("FAIL mrst_done: got %b, required 0", done_o); else n_pass++;
    pulse_start();
    step();
    n_total++; if (out_descriptor_data_o !== mk_desc(4, 32'd9, 20)) $display("FAIL mrst_first: got %h, required %h", out_descriptor_data_o, mk_desc(4, 32'd9, 20)); else n_pass++;
    step();
    n_total++; if (out_descriptor_data_o !== mk_desc(5, 32'd9, 21)) $display("FAIL mrst_second: got %h, required %h", out_descriptor_data_o, mk_desc(5, 32'd9, 21)); else n_pass++;
    n_total++; if (sent_count_o !== 32'd1) $display("FAIL mrst_sent1: got %0d, required 1", sent_count_o); else n_pass++;
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
    run_until_done(10, seen, lat);
    n_total++; if (!seen) $display("FAIL mrst_done_timeout: got no done, required done"); else n_pass++;
    n_total++; if (sent_count_o !== 32'd2) $display("FAIL mrst_sent2: got %0d, required 2", sent_count_o); else n_pass++;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset                  = 1'b1;
    cfg_start_i            = 1'b0;
    cfg_stop_i             = 1'b0;
    out_descriptor_ready_i = 1'b0;
    psrand_data_i          = 32'd0;
`ifdef GENAXIS_DESC_GEN_PAUSE_JITTER_EN
    cfg_pause_jitter_i     = 16'd0;
`endif
    configure(0, 2'd0, 0, 0, 32'd0, 1'b0, 0, 0);
    test_reset();
    test_fixed();
    test_incr_rr();
    test_boundaries();
    test_random();
    test_random_sweep();
    test_backpressure();
    test_stop_stalled();
    test_stop_accept();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/genaxis_descriptor_gen.md
Name: genaxis_descriptor_gen

Overview:
- Upstream stage of the AXI-Stream traffic generator: produces packet descriptors {channel[ID_WIDTH-1:0], pause[31:0], length[15:0]} on a valid/ready interface.
- Feeds the descriptor-to-AXIS stage directly.
- Software configures the length mode, channel mode, pause and packet count, then pulses start.
- The block emits descriptors back-to-back under backpressure until the count is exhausted or a stop is requested.

Parameters:
- ID_WIDTH, 10, channel (TID) field width; descriptor width is 48+ID_WIDTH.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cfg_start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_stop_i  in  1  one-cycle stop request; sampled only in RUN.
- cfg_pkt_count_i  in  32  descriptors to emit; 0 = unlimited.
- cfg_len_mode_i  in  2  0 fixed(min), 1 incrementing, 2 random, 3 treated as 0.
- cfg_len_min_i  in  16  minimum length in bytes.
- cfg_len_max_i  in  16  maximum length in bytes.
- cfg_pause_i  in  32  pause field value.
- cfg_chan_mode_i  in  1  0 fixed base channel, 1 round-robin.
- cfg_chan_base_i  in  ID_WIDTH  first channel.
- cfg_chan_num_i  in  ID_WIDTH  round-robin channel count; 0 treated as 1.
- psrand_data_i  in  32  pseudo-random word from the shared PRNG.
- out_descriptor_data_o  out  48+ID_WIDTH  {channel, pause, length}.
- out_descriptor_valid_o  out  1  descriptor valid.
- out_descriptor_ready_i  in  1  downstream ready.
- busy_o  out  1  high in LOAD/RUN/STOP.
- done_o  out  1  one-cycle pulse on return to IDLE from RUN/STOP.
- sent_count_o  out  32  handshakes since last start; wraps at 2^32.

Behaviour:
- Reset values: state IDLE; valid 0; busy 0; done 0; sent_count 0; data 0. Reset mid-packet drops valid the next cycle with no completion pulse.
- States: IDLE, LOAD, RUN, STOP.
- IDLE + cfg_start_i:
  - All cfg_* are captured into shadow registers; later cfg changes have no effect until the next start.
  - Clamps: min=0 becomes 1; max<min becomes max=min.
  - span = max-min; span_mask = smallest 2^k-1 >= span.
  - sent_count is cleared. Go to LOAD.
- LOAD (1 cycle): first descriptor is written to the output register. Go to RUN with valid=1, so the first valid appears 2 cycles after the start pulse.
- RUN, handshake (valid&ready):
  - sent_count increments.
  - If count!=0 and the incremented sent_count==count: valid<=0, done pulse next cycle, go to IDLE.
  - Otherwise the next descriptor is loaded in the same cycle, giving zero bubbles between descriptors.
- RUN, no handshake: data and valid are held stable (AXIS rule).
- Stop:
  - RUN + cfg_stop_i with handshake in the same cycle: treated as accepted-then-stop; go to IDLE, valid<=0, done pulse.
  - RUN + cfg_stop_i without a handshake: go to STOP.
  - STOP: the held descriptor stays valid until accepted, then valid<=0, go to IDLE, done pulse. No new descriptor is generated.
- Length generation:
  - Fixed: min.
  - Incrementing: min, min+1, ... max, then wraps to min.
  - Random: c = psrand_data_i[15:0] & span_mask; length = min + (c>span ? c-span-1 : c). Always within [min,max]; 16-bit arithmetic.
- Channel generation:
  - Fixed: base.
  - Round-robin: base, base+1, ... base+num-1, then back to base. Addition is modulo 2^ID_WIDTH.
- Pause field: cfg_pause_i as captured.
- cfg_start_i outside IDLE is ignored. cfg_stop_i in IDLE/LOAD is ignored.

Optional Feature:
- Macro: GENAXIS_DESC_GEN_PAUSE_JITTER_EN.
- Defined:
  - Adds port cfg_pause_jitter_i in 16, captured at start.
  - pause = cfg_pause + (psrand_data_i[31:16] & jitter), computed in 33 bits and saturated to 32'hFFFFFFFF.
- Undefined: port absent; pause = captured cfg_pause_i; psrand_data_i[31:16] unused.

Test Plan:
- Fixed mode: min=64, pause=10, chan base=3, count=4, ready=1.
  - Expect valid 2 cycles after start and 4 consecutive descriptors {3,10,64}.
  - Then valid=0, done pulse, sent_count=4.
- Incrementing + round-robin: min=1, max=3, base=5, num=2, count=5.
  - Expect lengths 1,2,3,1,2 and channels 5,6,5,6,5.
- Random: min=100, max=105, psrand[15:0]=16'h000F.
  - span=5, mask=7, c=7>5, so length=100+1=101.
  - Sweep psrand 0..65535; every length must be in [100,105].
- Backpressure: ready toggling 1010…, count=3.
  - Data stays stable while valid&!ready; exactly 3 handshakes.
- Stop while stalled: count=0 (unlimited), ready=0 when cfg_stop_i pulses.
  - Descriptor is held in STOP; ready=1 gives one handshake, then IDLE, done, valid=0.
- Reset asserted in RUN: valid=0, busy=0, sent_count=0 next cycle; a new start restarts at min length and base channel.
